// File: rtl/dmem_bridge.sv
// Data-memory bus bridge: core data port to byte-enabled synchronous SRAM.
// One access at a time; ackd_n holds the core off until the access completes.
module dmem_bridge #(
    parameter int AW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   dad,
    input  logic          mreq,
    input  logic          write,
    input  logic [1:0]    size,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ackd_n,
    output logic          misalign_err,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata;

    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wrep;
    logic [31:0]   w_shift;
    logic [31:0]   w_rd;
    logic          w_accept;
    logic          w_unused_dad;

    assign w_unused_dad = ^dad[31:AW+2];
    assign w_accept     = (r_state == S_IDLE) && mreq;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign rdata        = r_rdata;

    // Decode the incoming request: alignment, byte enables, lane replication.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wrep     = wdata;
        case (size)
            2'b00: begin
                w_misalign = (dad[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wrep     = wdata;
            end
            2'b01: begin
                w_misalign = dad[0];
                w_be       = dad[1] ? 4'b1100 : 4'b0011;
                w_wrep     = {2{wdata[15:0]}};
            end
            2'b10: begin
                w_misalign = 1'b0;
                w_be       = 4'b0001 << dad[1:0];
                w_wrep     = {4{wdata[7:0]}};
            end
            default: begin
                w_misalign = 1'b1;
                w_be       = 4'b0000;
                w_wrep     = wdata;
            end
        endcase
    end

    // Right-justify the addressed lane(s) of the SRAM word and zero-extend.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        w_rd    = 32'h0;
        case (r_size)
            2'b00:   w_rd = w_shift;
            2'b01:   w_rd = {16'h0, w_shift[15:0]};
            2'b10:   w_rd = {24'h0, w_shift[7:0]};
            default: w_rd = 32'h0;
        endcase
    end

    // State register; reset drops mem_cs at once since it decodes from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/SRAM strobes.
    always_comb begin
        w_next       = r_state;
        ackd_n       = 1'b1;
        misalign_err = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        case (r_state)
            S_IDLE: begin
                ackd_n = mreq;
                if (mreq) begin
                    w_next = w_misalign ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_cs = 1'b1;
                mem_we = r_we;
                mem_be = r_be;
                w_next = r_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                ackd_n       = 1'b0;
                misalign_err = r_err;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            ackd_n = 1'b1;
        end
    end

    // Latch the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= dad[AW+1:2];
            r_we    <= write;
            r_off   <= dad[1:0];
            r_size  <= size;
            r_be    <= w_be;
            r_wdata <= w_wrep;
            r_err   <= w_misalign;
        end
    end

    // Read-latency counter and load-data capture; rejected accesses clear rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
        end else begin
            if (w_accept && w_misalign) begin
                r_rdata <= 32'h0;
            end
            if (r_state == S_ISSUE && !r_we) begin
                r_cnt <= LAT_M1;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_rdata <= w_rd;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule
